// File: rtl/mapper_pkg.sv
// Shared types and defaults for the mapper and iterator blocks.
package mapper_pkg;

  localparam int unsigned COORD_W_DEFAULT = 32;
  localparam int unsigned FRAC_W_DEFAULT  = 28;

  typedef logic signed [COORD_W_DEFAULT-1:0] coord_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position with LANES stride and registered start-of-row / end-of-frame flags.
module raster_counter
  import mapper_pkg::*;
#(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480,
  parameter int unsigned LANES = 1,
  parameter int unsigned XW    = idx_width(H_RES),
  parameter int unsigned YW    = idx_width(V_RES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sol,
  output logic          eof,
  output logic          eor_c
);

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - LANES);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;

  assign eor_c = (x == X_LAST);

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (clear) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (advance) begin
      if (eor_c) begin
        x_nxt = '0;
        y_nxt = y + YW'(1);
      end else begin
        x_nxt = x + XW'(LANES);
      end
    end
  end

  // Flags are registered against the next position so they align with x/y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      y   <= '0;
      sol <= 1'b0;
      eof <= 1'b0;
    end else if (clear || advance) begin
      x   <= x_nxt;
      y   <= y_nxt;
      sol <= (x_nxt == '0);
      eof <= (x_nxt == X_LAST) && (y_nxt == Y_LAST);
    end
  end

endmodule

// File: rtl/coord_stream_mapper.sv
// Streams per-pixel complex-plane coordinates of a frame, LANES pixels per beat,
// using incremental accumulation only.
module coord_stream_mapper
  import mapper_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEFAULT,
  parameter int unsigned FRAC_W  = FRAC_W_DEFAULT,
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter int unsigned LANES   = 1,
  parameter int unsigned XW      = idx_width(H_RES),
  parameter int unsigned YW      = idx_width(V_RES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     continuous,
  input  logic [COORD_W-1:0]       re_origin,
  input  logic [COORD_W-1:0]       im_origin,
  input  logic [COORD_W-1:0]       delta_x,
  input  logic [COORD_W-1:0]       delta_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*COORD_W-1:0] out_re,
  output logic [COORD_W-1:0]       out_im,
  output logic [XW-1:0]            out_x,
  output logic [YW-1:0]            out_y,
  output logic                     out_sol,
  output logic                     out_eof,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned LANE_SH = (LANES > 1) ? $clog2(LANES) : 0;

  if (FRAC_W >= COORD_W) begin : g_frac_range_invalid
    $error("FRAC_W must be smaller than COORD_W");
  end

  state_t             state;
  logic               cont_r;
  logic [COORD_W-1:0] re_org;
  logic [COORD_W-1:0] im_org;
  logic [COORD_W-1:0] dy;
  logic [COORD_W-1:0] stride;
  logic [COORD_W-1:0] lane_re   [LANES];
  logic [COORD_W-1:0] offset    [LANES];
  logic [COORD_W-1:0] start_off [LANES];

  logic fire;
  logic eor_c;
  logic frame_go;
  logic cnt_clear;
  logic cnt_advance;

  // k*d by shift-and-add over the bits of the lane index.
  function automatic logic [COORD_W-1:0] lane_offset(input logic [COORD_W-1:0] d,
                                                     input int unsigned k);
    logic [COORD_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < 4; b++) begin
      if (k[b]) acc = acc + (d << b);
    end
    return acc;
  endfunction

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      start_off[k] = lane_offset(delta_x, k);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane_out
    assign out_re[k*COORD_W +: COORD_W] = lane_re[k];
  end

  assign fire        = out_valid && out_ready;
  assign frame_go    = (state == IDLE) && start && !abort;
  assign cnt_clear   = frame_go || ((state == RUN) && !abort && fire && out_eof);
  assign cnt_advance = (state == RUN) && !abort && fire && !out_eof;

  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .LANES (LANES),
    .XW    (XW),
    .YW    (YW)
  ) u_raster (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .x       (out_x),
    .y       (out_y),
    .sol     (out_sol),
    .eof     (out_eof),
    .eor_c   (eor_c)
  );

  // FSM, latched view configuration and per-lane coordinate accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      cont_r    <= 1'b0;
      re_org    <= '0;
      im_org    <= '0;
      dy        <= '0;
      stride    <= '0;
      out_im    <= '0;
      for (int k = 0; k < LANES; k++) begin
        lane_re[k] <= '0;
        offset[k]  <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_go) begin
            state     <= RUN;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            cont_r    <= continuous;
            re_org    <= re_origin;
            im_org    <= im_origin;
            dy        <= delta_y;
            stride    <= delta_x << LANE_SH;
            out_im    <= im_origin;
            for (int k = 0; k < LANES; k++) begin
              offset[k]  <= start_off[k];
              lane_re[k] <= re_origin + start_off[k];
            end
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end else if (fire) begin
            if (out_eof) begin
              done <= 1'b1;
              if (cont_r) begin
                out_im <= im_org;
                for (int k = 0; k < LANES; k++) lane_re[k] <= re_org + offset[k];
              end else begin
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
              end
            end else if (eor_c) begin
              out_im <= out_im + dy;
              for (int k = 0; k < LANES; k++) lane_re[k] <= re_org + offset[k];
            end else begin
              for (int k = 0; k < LANES; k++) lane_re[k] <= lane_re[k] + stride;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coord_stream_mapper.sv
// Self-checking bench: three mapper configurations, scoreboard of expected beats.
module tb_coord_stream_mapper;

  typedef struct packed {
    logic [127:0] re;
    logic [31:0]  im;
    logic [7:0]   x;
    logic [7:0]   y;
    logic         sol;
    logic         eof;
  } beat_t;

  typedef struct {
    int          sel;
    logic [31:0] ro, io, dx, dy;
    int          beat;
    int          lane;
    logic [31:0] exp_re;
    logic [31:0] exp_im;
    logic        exp_sol;
    logic        exp_eof;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_a, start_b, start_c;
  logic        abort, continuous, out_ready;
  logic [31:0] re_origin, im_origin, delta_x, delta_y;

  logic         va, vb, vc, busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic         sol_a, sol_b, sol_c, eof_a, eof_b, eof_c;
  logic [31:0]  re_a, re_c, im_a, im_b, im_c;
  logic [127:0] re_b;
  logic [1:0]   x_a;
  logic [2:0]   x_b;
  logic [0:0]   x_c, y_a, y_b, y_c;

  coord_stream_mapper #(.H_RES(4), .V_RES(2), .LANES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .continuous(continuous),
    .re_origin(re_origin), .im_origin(im_origin), .delta_x(delta_x), .delta_y(delta_y),
    .out_valid(va), .out_ready(out_ready), .out_re(re_a), .out_im(im_a), .out_x(x_a),
    .out_y(y_a), .out_sol(sol_a), .out_eof(eof_a), .busy(busy_a), .done(done_a));

  coord_stream_mapper #(.H_RES(8), .V_RES(1), .LANES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .continuous(continuous),
    .re_origin(re_origin), .im_origin(im_origin), .delta_x(delta_x), .delta_y(delta_y),
    .out_valid(vb), .out_ready(out_ready), .out_re(re_b), .out_im(im_b), .out_x(x_b),
    .out_y(y_b), .out_sol(sol_b), .out_eof(eof_b), .busy(busy_b), .done(done_b));

  coord_stream_mapper #(.H_RES(2), .V_RES(2), .LANES(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort), .continuous(continuous),
    .re_origin(re_origin), .im_origin(im_origin), .delta_x(delta_x), .delta_y(delta_y),
    .out_valid(vc), .out_ready(out_ready), .out_re(re_c), .out_im(im_c), .out_x(x_c),
    .out_y(y_c), .out_sol(sol_c), .out_eof(eof_c), .busy(busy_c), .done(done_c));

  int    sel;
  logic  m_valid, m_busy, m_done;
  beat_t m_beat;

  always_comb begin
    m_valid = 1'b0;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_beat  = '0;
    case (sel)
      0: begin
        m_valid = va; m_busy = busy_a; m_done = done_a;
        m_beat.re = {96'b0, re_a}; m_beat.im = im_a;
        m_beat.x = {6'b0, x_a}; m_beat.y = {7'b0, y_a};
        m_beat.sol = sol_a; m_beat.eof = eof_a;
      end
      1: begin
        m_valid = vb; m_busy = busy_b; m_done = done_b;
        m_beat.re = re_b; m_beat.im = im_b;
        m_beat.x = {5'b0, x_b}; m_beat.y = {7'b0, y_b};
        m_beat.sol = sol_b; m_beat.eof = eof_b;
      end
      default: begin
        m_valid = vc; m_busy = busy_c; m_done = done_c;
        m_beat.re = {96'b0, re_c}; m_beat.im = im_c;
        m_beat.x = {7'b0, x_c}; m_beat.y = {7'b0, y_c};
        m_beat.sol = sol_c; m_beat.eof = eof_c;
      end
    endcase
  end

  int    checks = 0;
  int    failures = 0;
  beat_t exp_q[$];
  beat_t cap[64];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual re=%0h im=%0h x=%0d y=%0d sol=%b eof=%b required re=%0h im=%0h x=%0d y=%0d sol=%b eof=%b",
               name, act.re, act.im, act.x, act.y, act.sol, act.eof,
               exp.re, exp.im, exp.x, exp.y, exp.sol, exp.eof);
    end
  endtask

  function automatic int hres(input int s);
    return (s == 0) ? 4 : (s == 1) ? 8 : 2;
  endfunction
  function automatic int vres(input int s);
    return (s == 1) ? 1 : 2;
  endfunction
  function automatic int lanes(input int s);
    return (s == 1) ? 4 : 1;
  endfunction

  task automatic set_start(input int s, input logic v);
    case (s)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Reference model: direct origin + index*delta per pixel.
  task automatic push_frame(input int s, input logic [31:0] ro, io, dx, dy);
    for (int yy = 0; yy < vres(s); yy++) begin
      for (int xx = 0; xx < hres(s); xx += lanes(s)) begin
        beat_t b;
        b = '0;
        for (int k = 0; k < lanes(s); k++) b.re[k*32 +: 32] = ro + 32'(xx + k) * dx;
        b.im  = io + 32'(yy) * dy;
        b.x   = 8'(xx);
        b.y   = 8'(yy);
        b.sol = (xx == 0);
        b.eof = (xx == hres(s) - lanes(s)) && (yy == vres(s) - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic run_frame(input int s, input logic [31:0] ro, io, dx, dy,
                           input int stall_at, input int stall_len);
    int    beats, stalled, nexp;
    bit    ended;
    beat_t e;
    @(negedge clk);
    sel = s; re_origin = ro; im_origin = io; delta_x = dx; delta_y = dy;
    continuous = 1'b0; abort = 1'b0; out_ready = 1'b1;
    set_start(s, 1'b1);
    exp_q.delete();
    push_frame(s, ro, io, dx, dy);
    nexp = exp_q.size();
    @(negedge clk);
    set_start(s, 1'b0);
    re_origin = ~ro; im_origin = ~io; delta_x = 32'h1234_5678; delta_y = 32'h0F0F_0F0F;
    chk("latency_valid", 128'(m_valid), 128'(1'b1));
    beats = 0; stalled = 0; ended = 0;
    for (int cyc = 0; cyc < 100 && !ended; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (beats == stall_at && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
        if (m_valid && exp_q.size() > 0) chk_beat("stall_hold", m_beat, exp_q[0]);
        else chk("stall_valid", 128'(m_valid), 128'(1'b1));
      end else begin
        out_ready = 1'b1;
      end
      if (m_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 128'(1'b1), 128'(1'b0));
        end else begin
          e = exp_q.pop_front();
          chk_beat("beat", m_beat, e);
          cap[beats] = m_beat;
          beats++;
          if (e.eof) begin
            @(negedge clk);
            chk("done_pulse", 128'(m_done), 128'(1'b1));
            chk("end_valid", 128'(m_valid), 128'(1'b0));
            chk("end_busy", 128'(m_busy), 128'(1'b0));
            ended = 1;
          end
        end
      end
    end
    out_ready = 1'b1;
    chk("frame_beats", 128'(beats), 128'(nexp));
    chk("frame_ended", 128'(ended), 128'(1'b1));
  endtask

  vec_t vecs[7];

  initial begin
    int    beats, dones, prev_eof;
    bit    aborted;
    beat_t e;

    vecs[0] = '{0, 32'hE000_0000, 32'h1000_0000, 32'h0010_0000, 32'hFFF0_0000, 3, 0, 32'hE030_0000, 32'h1000_0000, 1'b0, 1'b0};
    vecs[1] = '{0, 32'hE000_0000, 32'h1000_0000, 32'h0010_0000, 32'hFFF0_0000, 4, 0, 32'hE000_0000, 32'h0FF0_0000, 1'b1, 1'b0};
    vecs[2] = '{0, 32'hE000_0000, 32'h1000_0000, 32'h0010_0000, 32'hFFF0_0000, 7, 0, 32'hE030_0000, 32'h0FF0_0000, 1'b0, 1'b1};
    vecs[3] = '{1, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 0, 3, 32'h0003_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4] = '{1, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 1, 0, 32'h0004_0000, 32'h0000_0000, 1'b0, 1'b1};
    vecs[5] = '{1, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 1, 3, 32'h0007_0000, 32'h0000_0000, 1'b0, 1'b1};
    vecs[6] = '{0, 32'h7FF0_0000, 32'h0000_0000, 32'h0010_0000, 32'h0000_0000, 1, 0, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0};

    rst_n = 1'b0; sel = 0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    abort = 1'b0; continuous = 1'b0; out_ready = 1'b1;
    re_origin = '0; im_origin = '0; delta_x = '0; delta_y = '0;

    #3;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("reset_valid", 128'(m_valid), 128'(1'b0));
      chk("reset_busy", 128'(m_busy), 128'(1'b0));
      chk("reset_done", 128'(m_done), 128'(1'b0));
      chk_beat("reset_data", m_beat, '0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(0, 32'hE000_0000, 32'h1000_0000, 32'h0010_0000, 32'hFFF0_0000, -1, 0);

    foreach (vecs[i]) begin
      run_frame(vecs[i].sel, vecs[i].ro, vecs[i].io, vecs[i].dx, vecs[i].dy, -1, 0);
      chk($sformatf("vec%0d_re", i), 128'(cap[vecs[i].beat].re[vecs[i].lane*32 +: 32]), 128'(vecs[i].exp_re));
      chk($sformatf("vec%0d_im", i), 128'(cap[vecs[i].beat].im), 128'(vecs[i].exp_im));
      chk($sformatf("vec%0d_sol", i), 128'(cap[vecs[i].beat].sol), 128'(vecs[i].exp_sol));
      chk($sformatf("vec%0d_eof", i), 128'(cap[vecs[i].beat].eof), 128'(vecs[i].exp_eof));
    end

    run_frame(0, 32'hE000_0000, 32'h1000_0000, 32'h0010_0000, 32'hFFF0_0000, 2, 3);
    chk("stall_beat2_re", 128'(cap[2].re[31:0]), 128'(32'hE020_0000));
    chk("stall_beat2_x", 128'(cap[2].x), 128'(8'd2));

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    sel = 0; set_start(0, 1'b1); abort = 1'b1;
    @(negedge clk);
    set_start(0, 1'b0); abort = 1'b0;
    chk("start_abort_valid", 128'(m_valid), 128'(1'b0));
    chk("start_abort_busy", 128'(m_busy), 128'(1'b0));

    // continuous 2x2 frame, abort on beat 6
    @(negedge clk);
    sel = 2; re_origin = 32'h0000_1000; im_origin = 32'h0000_0000;
    delta_x = 32'h0000_0010; delta_y = 32'h0000_0100;
    continuous = 1'b1; out_ready = 1'b1; set_start(2, 1'b1);
    exp_q.delete();
    push_frame(2, 32'h0000_1000, 32'h0, 32'h10, 32'h100);
    push_frame(2, 32'h0000_1000, 32'h0, 32'h10, 32'h100);
    @(negedge clk);
    set_start(2, 1'b0); continuous = 1'b0;
    beats = 0; dones = 0; prev_eof = 0; aborted = 0;
    for (int cyc = 0; cyc < 60 && !aborted; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (m_done) dones++;
      if (prev_eof != 0) begin
        chk("cont_done", 128'(m_done), 128'(1'b1));
        chk("cont_no_bubble", 128'(m_valid), 128'(1'b1));
        prev_eof = 0;
      end
      if (beats == 6) abort = 1'b1;
      if (m_valid && out_ready) begin
        e = exp_q.pop_front();
        chk_beat("cont_beat", m_beat, e);
        beats++;
        prev_eof = int'(e.eof);
      end
      if (abort) aborted = 1;
    end
    chk("cont_aborted", 128'(aborted), 128'(1'b1));
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", 128'(m_valid), 128'(1'b0));
    chk("abort_busy", 128'(m_busy), 128'(1'b0));
    repeat (10) begin
      @(negedge clk);
      if (m_done) dones++;
    end
    chk("abort_idle_valid", 128'(m_valid), 128'(1'b0));
    chk("cont_done_count", 128'(dones), 128'(1));

    // asynchronous reset in the middle of a frame
    @(negedge clk);
    sel = 0; re_origin = 32'hE000_0000; im_origin = 32'h1000_0000;
    delta_x = 32'h0010_0000; delta_y = 32'hFFF0_0000; set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_valid", 128'(m_valid), 128'(1'b0));
    chk("midreset_busy", 128'(m_busy), 128'(1'b0));
    chk("midreset_done", 128'(m_done), 128'(1'b0));
    chk_beat("midreset_data", m_beat, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 32'hE000_0000, 32'h1000_0000, 32'h0010_0000, 32'hFFF0_0000, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coord_stream_mapper.md
# coord_stream_mapper

Raster-scanning pixel-to-complex-plane coordinate generator. It is the parametrised successor to the single-pixel mapper. On a start pulse it latches the view configuration, then streams the fixed-point (re, im) coordinates of every pixel in the frame, LANES pixels per beat, over a valid/ready interface to the iteration engines. Coordinates are produced by exact incremental accumulation, so no multipliers sit in the per-pixel path.

## Interface
- COORD_W, 32: coordinate width, signed two's-complement fixed point.
- FRAC_W, 28: fractional bits (1.0 = 1<<FRAC_W); affects only interpretation, not arithmetic.
- H_RES, 640: pixels per row; must be a multiple of LANES.
- V_RES, 480: rows per frame.
- LANES, 1: pixels per output beat (1, 2, 4 or 8).
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- abort  in  1  terminate the current frame.
- continuous  in  1  sampled at start; 1 = restart at frame end until abort.
- re_origin, im_origin  in  COORD_W  coordinate of pixel (0,0); sampled at start.
- delta_x, delta_y  in  COORD_W  signed per-pixel / per-row step; sampled at start.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat.
- out_re  out  LANES*COORD_W  lane k in bits [k*COORD_W +: COORD_W] = pixel x+k.
- out_im  out  COORD_W  shared by all lanes.
- out_x  out  $clog2(H_RES)  x of lane 0.
- out_y  out  $clog2(V_RES)  row.
- out_sol, out_eof  out  1  first beat of row / last beat of frame.
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse after the last beat of a frame is accepted.

## Operation
- States: IDLE, RUN. IDLE -> RUN on start. In RUN, the last beat is accepted -> IDLE and done=1 if continuous=0; if continuous=1, done=1, stay in RUN, x=y=0, coordinates reload from the latched origins. Abort in RUN -> IDLE with no done.
- The step register is loaded at start with stride = LANES*delta_x. The lane offsets k*delta_x are computed once at start by shift-and-add (LANES is a power of two) and held.
- Lane k output is row_re + offset_k; row_re is the lane-0 accumulator.
- Accepted beat (out_valid & out_ready), not end of row: row_re += stride, x += LANES.
- Accepted beat at end of row (x = H_RES-LANES): row_re = re_origin, x = 0, im += delta_y, y += 1.
- All arithmetic is modulo 2^COORD_W (wrap, no saturation). Results equal origin + index*delta mod 2^COORD_W exactly.
- out_sol = (x==0). out_eof = (x==H_RES-LANES && y==V_RES-1).
- Configuration inputs are ignored outside the start cycle.
- A start while in RUN is ignored. If start and abort arrive in the same cycle in IDLE, abort wins (stay IDLE).

## Timing
- Reset values: out_valid=0, busy=0, done=0, out_sol=0, out_eof=0, all data outputs and counters 0, state IDLE.
- Start accepted at edge n -> out_valid=1 with pixel (0,0) from edge n+1 (one-cycle latency). The offset computation completes within that cycle.
- Throughput is one beat per cycle while out_ready=1.
- While out_valid & !out_ready, all out_* signals hold stable. out_valid never drops without a handshake, except on abort or reset.
- abort at edge n -> out_valid=0 and busy=0 from n+1. A beat handshaken in the same cycle as abort counts as consumed.
- done is asserted in the cycle after the eof handshake. In single-frame mode out_valid=0 in that same cycle. In continuous mode, pixel (0,0) is valid in that same cycle (no bubble).
- Reset asserted mid-frame clears everything immediately (asynchronously). There is no resume.

## Structure
- Shared package mapper_pkg holds: state enum (IDLE, RUN); typedef coord_t = logic signed [COORD_W-1:0] as a parametrised localparam default; the FRAC_W default. Existing and future mapper/iterator blocks share this package.
- One sub-module: raster_counter (x/y counter with LANES stride, end-of-row/end-of-frame flags, advance and clear inputs). Accumulators, FSM and output register stay in coord_stream_mapper.

## Test plan
- Reset: rst_n low mid-stream -> out_valid=0, busy=0, out_re=0, done=0 immediately; start after release yields pixel (0,0) one cycle later.
- H_RES=4, V_RES=2, LANES=1, re_origin=0xE0000000, delta_x=0x00100000, im_origin=0x10000000, delta_y=0xFFF00000, out_ready=1 -> 8 beats. Beat3: re=0xE0300000. Beat4: re=0xE0000000, im=0x0FF00000, sol=1. Beat7: eof=1. done one cycle later, busy=0.
- Backpressure: same frame, out_ready=0 for 3 cycles at beat2 -> out_re=0xE0200000 and x=2 held stable. Resumes with beat3; 8 beats total, no duplicates.
- LANES=4, H_RES=8, V_RES=1, re_origin=0, delta_x=0x00010000 -> beat0 lanes 0x0,0x10000,0x20000,0x30000. Beat1 lanes 0x40000..0x70000 with eof=1.
- Wrap: re_origin=0x7FF00000, delta_x=0x00100000 -> pixel1 re=0x80000000 (modulo wrap, no saturation).
- continuous=1, 2x2 frame -> done pulses after beat3, pixel (0,0) re-emitted with no bubble. abort at beat6 -> out_valid=0 next cycle, no further done.
